// File: rtl/ps2_kbd_device_tx_if.sv
// PS/2 open-drain line pair as seen from the device (keyboard) end.
// Drives are 1 = release, 0 = pull low; the sensed lines are the wired-AND result.
interface ps2_kbd_device_tx_if;
    logic ps2_clk_i;
    logic ps2_data_i;
    logic ps2_clk_o;
    logic ps2_data_o;

    modport master (
        input  ps2_clk_i,
        input  ps2_data_i,
        output ps2_clk_o,
        output ps2_data_o
    );

    modport slave (
        output ps2_clk_i,
        output ps2_data_i,
        input  ps2_clk_o,
        input  ps2_data_o
    );
endinterface

// File: rtl/ps2_kbd_device_tx.sv
// Keyboard-side PS/2 transmitter: turns MiSTer ps2_key toggle events into scan-code
// bytes, queues them atomically and clocks them out, backing off on host inhibit.
module ps2_kbd_device_tx #(
    parameter int HALF_PERIOD = 1000,
    parameter int FIFO_AW     = 3,
    parameter int IDLE_CYCLES = 1400
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [10:0]          ps2_key,
    ps2_kbd_device_tx_if.master  ps2,
    output logic                 busy,
    output logic                 overflow,
    output logic [FIFO_AW:0]     fifo_level
);

    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int LW      = FIFO_AW + 1;
    localparam int CNT_MAX = (2 * HALF_PERIOD > IDLE_CYCLES) ? 2 * HALF_PERIOD : IDLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   HALF_LAST = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(2 * HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]   IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   SETTLE    = CNT_W'(16);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [FIFO_AW-1:0] PTR_TWO   = FIFO_AW'(2);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_BUS = 3'd1;
    localparam logic [2:0] ST_BIT_HI   = 3'd2;
    localparam logic [2:0] ST_BIT_LO   = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    logic [1:0]         clkSync_q;
    logic [1:0]         dataSync_q;
    logic               busClk;
    logic               busData;

    logic               armed_q;
    logic               keyLast_q;
    logic               keyEvent;
    logic [1:0]         evLen;
    logic [7:0]         evByte0;
    logic [7:0]         evByte1;
    logic [7:0]         evByte2;

    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wrPtr_q;
    logic [FIFO_AW-1:0] rdPtr_q;
    logic [FIFO_AW-1:0] wrAddr1;
    logic [FIFO_AW-1:0] wrAddr2;
    logic [LW-1:0]      level_q;
    logic [LW-1:0]      level_d;
    logic [LW-1:0]      freeSpace;
    logic [7:0]         headByte;
    logic               doPush;
    logic               doPop;
    logic               overflow_q;

    logic [2:0]         state_q;
    logic [2:0]         state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [3:0]         bitIdx_q;
    logic [3:0]         bitIdx_d;
    logic [3:0]         nextIdx;
    logic [10:0]        frame_q;
    logic [10:0]        frame_d;
    logic               clkOut_q;
    logic               clkOut_d;
    logic               dataOut_q;
    logic               dataOut_d;

    assign busClk  = clkSync_q[1];
    assign busData = dataSync_q[1];

    // Prefix order on the wire is E0, then F0, then the code itself.
    always_comb begin
        keyEvent  = armed_q && (ps2_key[10] != keyLast_q);
        evLen     = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
        evByte0   = ps2_key[8] ? 8'hE0 : (ps2_key[9] ? ps2_key[7:0] : 8'hF0);
        evByte1   = (ps2_key[8] && !ps2_key[9]) ? 8'hF0 : ps2_key[7:0];
        evByte2   = ps2_key[7:0];
        freeSpace = LW'(DEPTH) - level_q;
        doPush    = keyEvent && (LW'(evLen) <= freeSpace);
        wrAddr1   = wrPtr_q + PTR_ONE;
        wrAddr2   = wrPtr_q + PTR_TWO;
        headByte  = mem_q[rdPtr_q];
        level_d   = level_q + (doPush ? LW'(evLen) : LW'(0)) - (doPop ? LW'(1) : LW'(0));
    end

    always_ff @(posedge clk_sys) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= evByte0;
            if (evLen > 2'd1) mem_q[wrAddr1] <= evByte1;
            if (evLen > 2'd2) mem_q[wrAddr2] <= evByte2;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitIdx_d  = bitIdx_q;
        frame_d   = frame_q;
        clkOut_d  = clkOut_q;
        dataOut_d = dataOut_q;
        doPop     = 1'b0;
        nextIdx   = bitIdx_q + 4'd1;
        case (state_q)
            ST_IDLE: begin
                clkOut_d  = 1'b1;
                dataOut_d = 1'b1;
                if (level_q != '0) begin
                    frame_d = {1'b1, ~^headByte, headByte, 1'b0};
                    cnt_d   = '0;
                    state_d = ST_WAIT_BUS;
                end
            end
            ST_WAIT_BUS: begin
                if (busClk && busData) begin
                    if (cnt_q == IDLE_LAST) begin
                        cnt_d     = '0;
                        bitIdx_d  = '0;
                        dataOut_d = frame_q[0];
                        state_d   = ST_BIT_HI;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            ST_BIT_HI: begin
                // The stop bit is committed; only earlier bits can be aborted.
                if (cnt_q >= SETTLE && !busClk && bitIdx_q != 4'd10) begin
                    clkOut_d  = 1'b1;
                    dataOut_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_WAIT_BUS;
                end else if (cnt_q == HALF_LAST) begin
                    cnt_d    = '0;
                    clkOut_d = 1'b0;
                    state_d  = ST_BIT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BIT_LO: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d    = '0;
                    clkOut_d = 1'b1;
                    if (bitIdx_q == 4'd10) begin
                        doPop     = 1'b1;
                        dataOut_d = 1'b1;
                        state_d   = ST_GAP;
                    end else begin
                        bitIdx_d  = nextIdx;
                        dataOut_d = frame_q[nextIdx];
                        state_d   = ST_BIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d     = '0;
                clkOut_d  = 1'b1;
                dataOut_d = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // The first cycle out of reset only samples the toggle so a stale level is not an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            clkSync_q  <= 2'b11;
            dataSync_q <= 2'b11;
            armed_q    <= 1'b0;
            keyLast_q  <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            frame_q    <= '1;
            clkOut_q   <= 1'b1;
            dataOut_q  <= 1'b1;
        end else begin
            clkSync_q  <= {clkSync_q[0], ps2.ps2_clk_i};
            dataSync_q <= {dataSync_q[0], ps2.ps2_data_i};
            armed_q    <= 1'b1;
            keyLast_q  <= ps2_key[10];
            wrPtr_q    <= doPush ? wrPtr_q + FIFO_AW'(evLen) : wrPtr_q;
            rdPtr_q    <= doPop ? rdPtr_q + PTR_ONE : rdPtr_q;
            level_q    <= level_d;
            overflow_q <= keyEvent && !doPush;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            frame_q    <= frame_d;
            clkOut_q   <= clkOut_d;
            dataOut_q  <= dataOut_d;
        end
    end

    assign ps2.ps2_clk_o  = clkOut_q;
    assign ps2.ps2_data_o = dataOut_q;
    assign busy           = (state_q != ST_IDLE) || (level_q != '0);
    assign overflow       = overflow_q;
    assign fifo_level     = level_q;

endmodule
